// File: rtl/p_hit_pkg.sv
// Shared types and constants for the p_hit_1 dispatch block.
// Optional statistics are enabled with the P_HIT_DISPATCH_STATS_EN macro (see p_hit_dispatch).
package p_hit_pkg;

  localparam int VEC_D_BITS = 32;
  localparam int VEC_Q_BITS = 16;
  localparam int STAT_W     = 32;

  // Three signed fixed-point words, index 0 = x, 1 = y, 2 = z.
  typedef logic signed [2:0][VEC_D_BITS-1:0] vec3_t;

  // Encoding is {valid[1], valid[0]} of the two holding slots.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PT1_PEND = 2'b01,
    PT2_PEND = 2'b10,
    BOTH     = 2'b11
  } dispatch_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/p_hit_dispatch_if.sv
// Upstream FWFT FIFO head plus the two p_hit_1 write ports.
// master = dispatcher side, slave = FIFO / p_hit_1 side.
interface p_hit_dispatch_if #(
  parameter int D_BITS = 32
);

  logic                             in_empty;
  logic                             in_rd_en;
  logic signed [2:0][D_BITS-1:0]    tri_normal;
  logic signed [2:0][D_BITS-1:0]    v0;
  logic signed [2:0][D_BITS-1:0]    origin;
  logic signed [2:0][D_BITS-1:0]    dir;

  logic [1:0]                       out_full;
  logic [1:0]                       out_wr_en;
  logic signed [2:0][D_BITS-1:0]    tri_normal_1;
  logic signed [2:0][D_BITS-1:0]    v0_out;
  logic signed [2:0][D_BITS-1:0]    origin_out;
  logic signed [2:0][D_BITS-1:0]    tri_normal_2;
  logic signed [2:0][D_BITS-1:0]    dir_out;

  modport master (
    input  in_empty, tri_normal, v0, origin, dir, out_full,
    output in_rd_en, out_wr_en, tri_normal_1, v0_out, origin_out, tri_normal_2, dir_out
  );

  modport slave (
    output in_empty, tri_normal, v0, origin, dir, out_full,
    input  in_rd_en, out_wr_en, tri_normal_1, v0_out, origin_out, tri_normal_2, dir_out
  );

endinterface

// File: rtl/p_hit_slot.sv
// One output holding slot: data register, valid bit and the wr_en/full handshake.
module p_hit_slot #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_full,
  output logic         o_wr_en,
  output logic         o_free,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_wr_en;

  // A write happens whenever data is held and the sink has room.
  always_comb begin
    w_wr_en = r_valid && !i_full;
    o_wr_en = w_wr_en;
    o_free  = !r_valid || w_wr_en;
    o_data  = r_data;
  end

  // Data only changes on a load, which the parent issues only when the slot is free,
  // so held data stays stable until it is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_wr_en) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/p_hit_dispatch.sv
// Pops ray/triangle records from an FWFT FIFO and writes them to both p_hit_1
// ports in lockstep, each port with its own holding slot.
// Optional macro P_HIT_DISPATCH_STATS_EN adds stat_records / stat_stall counters.
module p_hit_dispatch
  import p_hit_pkg::*;
#(
  parameter int D_BITS = VEC_D_BITS,
  parameter int Q_BITS = VEC_Q_BITS
) (
  input  logic                clock,
  input  logic                reset,
  p_hit_dispatch_if.master    bus
`ifdef P_HIT_DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_records,
  output logic [STAT_W-1:0]   stat_stall
`endif
);

  localparam int PT1_W = 9 * D_BITS;
  localparam int PT2_W = 6 * D_BITS;

  dispatch_state_t  r_state;
  dispatch_state_t  w_state_next;
  logic             w_pop;
  logic [1:0]       w_wr_en;
  logic [1:0]       w_free;
  logic [PT1_W-1:0] w_pt1_data;
  logic [PT2_W-1:0] w_pt2_data;

  // Port 0 slot: normal, v0, origin.
  p_hit_slot #(.W(PT1_W)) u_slot_pt1 (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_pop),
    .i_data  ({bus.tri_normal, bus.v0, bus.origin}),
    .i_full  (bus.out_full[0]),
    .o_wr_en (w_wr_en[0]),
    .o_free  (w_free[0]),
    .o_data  (w_pt1_data)
  );

  // Port 1 slot: normal, dir.
  p_hit_slot #(.W(PT2_W)) u_slot_pt2 (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_pop),
    .i_data  ({bus.tri_normal, bus.dir}),
    .i_full  (bus.out_full[1]),
    .o_wr_en (w_wr_en[1]),
    .o_free  (w_free[1]),
    .o_data  (w_pt2_data)
  );

  assign {bus.tri_normal_1, bus.v0_out, bus.origin_out} = w_pt1_data;
  assign {bus.tri_normal_2, bus.dir_out}                = w_pt2_data;

  // State register: tracks which slots still hold an unwritten record.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state from this cycle's writes and pop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pop) w_state_next = BOTH;
      end
      BOTH: begin
        if (w_pop)                       w_state_next = BOTH;
        else if (w_wr_en[0] && w_wr_en[1]) w_state_next = IDLE;
        else if (w_wr_en[0])             w_state_next = PT2_PEND;
        else if (w_wr_en[1])             w_state_next = PT1_PEND;
        else                             w_state_next = BOTH;
      end
      PT1_PEND: begin
        if (w_wr_en[0]) w_state_next = w_pop ? BOTH : IDLE;
      end
      PT2_PEND: begin
        if (w_wr_en[1]) w_state_next = w_pop ? BOTH : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pop only when both slots can take the head, so a record is never split.
  always_comb begin
    w_pop         = !reset && !bus.in_empty && w_free[0] && w_free[1];
    bus.in_rd_en  = w_pop;
    bus.out_wr_en = w_wr_en;
  end

`ifdef P_HIT_DISPATCH_STATS_EN
  logic [STAT_W-1:0] r_stat_records;
  logic [STAT_W-1:0] r_stat_stall;
  logic [1:0]        w_valid;
  logic              w_rec_done;
  logic              w_stall;

  // A record is done when every slot still holding it is written this cycle.
  always_comb begin
    w_valid    = r_state;
    w_rec_done = (|w_valid) && (!w_valid[0] || w_wr_en[0]) && (!w_valid[1] || w_wr_en[1]);
    w_stall    = |(w_valid & bus.out_full);
  end

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_records <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_rec_done) r_stat_records <= sat_inc(r_stat_records);
      if (w_stall)    r_stat_stall   <= sat_inc(r_stat_stall);
    end
  end

  assign stat_records = r_stat_records;
  assign stat_stall   = r_stat_stall;
`endif

endmodule
